// File: rtl/even_toggle_gen_if.sv
// Control/serial bundle between the test sequencer (master) and the
// toggle-pair generator (slave).
interface even_toggle_gen_if #(
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 4
);
  logic              start;
  logic [CNT_W-1:0]  pairs;
  logic [HOLD_W-1:0] hold;
  logic              init_lvl;
  logic              d_out;
  logic              busy;
  logic              pair_strobe;
  logic              done;

  modport master (
    output start, pairs, hold, init_lvl,
    input  d_out, busy, pair_strobe, done
  );

  modport slave (
    input  start, pairs, hold, init_lvl,
    output d_out, busy, pair_strobe, done
  );
endinterface

// File: rtl/even_toggle_gen.sv
// Toggle-pair stimulus generator: lead-in level, then P toggle pairs with each
// level held H cycles. Outputs are registered copies of the next-state values.
module even_toggle_gen #(
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 4
) (
  input logic              clk,
  input logic              reset_n,
  even_toggle_gen_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAD = 3'd1,
    TOG1 = 3'd2,
    TOG2 = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
  logic [HOLD_W-1:0] h_r, h_s, h_in_s;
  logic [CNT_W-1:0]  pair_cnt_r, pair_cnt_s;
  logic              lvl_r, lvl_s;
  logic              d_out_r, d_out_s;
  logic              busy_r, busy_s;
  logic              strobe_r, strobe_s;
  logic              done_r, done_s;
  logic              hold_exp_s;

  // Next-state, counter and output computation.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    h_s        = h_r;
    pair_cnt_s = pair_cnt_r;
    lvl_s      = lvl_r;
    d_out_s    = d_out_r;
    busy_s     = busy_r;
    strobe_s   = 1'b0;
    done_s     = 1'b0;
    hold_exp_s = (hold_cnt_r == HOLD_ZERO);
    h_in_s     = (bus.hold == HOLD_ZERO) ? HOLD_ONE : bus.hold;

    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (bus.start) begin
          h_s        = h_in_s;
          lvl_s      = bus.init_lvl;
          pair_cnt_s = bus.pairs;
          busy_s     = 1'b1;
          if (bus.pairs == CNT_ZERO) begin
            state_s = FIN;
            done_s  = 1'b1;
          end else begin
            state_s    = LEAD;
            hold_cnt_s = h_in_s - HOLD_ONE;
            d_out_s    = bus.init_lvl;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LEAD: begin
        if (hold_exp_s) begin
          state_s    = TOG1;
          hold_cnt_s = h_r - HOLD_ONE;
          d_out_s    = ~lvl_r;
        end else begin
          hold_cnt_s = hold_cnt_r - HOLD_ONE;
        end
      end
      TOG1: begin
        if (hold_exp_s) begin
          state_s    = TOG2;
          hold_cnt_s = h_r - HOLD_ONE;
          d_out_s    = lvl_r;
          strobe_s   = 1'b1;
          // Saturating decrement: the counter never wraps below zero.
          if (pair_cnt_r != CNT_ZERO) begin
            pair_cnt_s = pair_cnt_r - CNT_ONE;
          end else begin
            pair_cnt_s = CNT_ZERO;
          end
        end else begin
          hold_cnt_s = hold_cnt_r - HOLD_ONE;
        end
      end
      TOG2: begin
        if (hold_exp_s) begin
          if (pair_cnt_r != CNT_ZERO) begin
            state_s    = TOG1;
            hold_cnt_s = h_r - HOLD_ONE;
            d_out_s    = ~lvl_r;
          end else begin
            state_s = FIN;
            done_s  = 1'b1;
            d_out_s = lvl_r;
          end
        end else begin
          hold_cnt_s = hold_cnt_r - HOLD_ONE;
        end
      end
      FIN: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s    = IDLE;
        busy_s     = 1'b0;
        hold_cnt_s = HOLD_ZERO;
        pair_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // State, counters, latched parameters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      hold_cnt_r <= HOLD_ZERO;
      h_r        <= HOLD_ZERO;
      pair_cnt_r <= CNT_ZERO;
      lvl_r      <= 1'b0;
      d_out_r    <= 1'b0;
      busy_r     <= 1'b0;
      strobe_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      h_r        <= h_s;
      pair_cnt_r <= pair_cnt_s;
      lvl_r      <= lvl_s;
      d_out_r    <= d_out_s;
      busy_r     <= busy_s;
      strobe_r   <= strobe_s;
      done_r     <= done_s;
    end
  end

  assign bus.d_out       = d_out_r;
  assign bus.busy        = busy_r;
  assign bus.pair_strobe = strobe_r;
  assign bus.done        = done_r;
endmodule

// File: tb/tb_even_toggle_gen.sv
// Bench for even_toggle_gen: per-cycle waveform model plus directed sequences
// with hand-computed expectations.
module tb_even_toggle_gen;
  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail = 0;

  even_toggle_gen_if #(.CNT_W(8), .HOLD_W(4)) bus ();
  even_toggle_gen #(.CNT_W(8), .HOLD_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each accepted request expands into its full per-cycle waveform
  // {d_out, busy, pair_strobe, done}, followed by the mandatory idle cycle.
  logic [3:0] q[$];
  logic [3:0] exp_o = 4'b0000;

  function automatic void build(input logic [7:0] p, input logic [3:0] hold, input logic l);
    int h;
    h = (hold == 4'd0) ? 1 : int'(hold);
    if (p == 8'd0) begin
      q.push_back({exp_o[3], 3'b101});
      q.push_back({exp_o[3], 3'b000});
    end else begin
      for (int i = 0; i < h; i++) q.push_back({l, 3'b100});
      for (int k = 0; k < int'(p); k++) begin
        for (int i = 0; i < h; i++) q.push_back({~l, 3'b100});
        for (int i = 0; i < h; i++) q.push_back({l, 1'b1, (i == 0), 1'b0});
      end
      q.push_back({l, 3'b101});
      q.push_back({l, 3'b000});
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      exp_o <= 4'b0000;
    end else begin
      if (q.size() == 0 && bus.start) build(bus.pairs, bus.hold, bus.init_lvl);
      if (q.size() != 0) exp_o <= q.pop_front();
      else exp_o <= {exp_o[3], 3'b000};
    end
  end

  always @(negedge clk) begin
    check("cycle_outputs", 64'({bus.d_out, bus.busy, bus.pair_strobe, bus.done}), 64'(exp_o));
  end

  task automatic run(input logic [7:0] p, input logic [3:0] h, input logic l, input bit poke,
                     input int limit, output int done_at, output int strobes,
                     output logic [63:0] dv, output logic [63:0] sv);
    done_at = 0; strobes = 0; dv = 64'd0; sv = 64'd0;
    @(negedge clk);
    bus.start = 1'b1; bus.pairs = p; bus.hold = h; bus.init_lvl = l;
    for (int c = 1; c <= limit && done_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (poke && c == 3) begin
        bus.start = 1'b1; bus.pairs = 8'd1; bus.hold = 4'd0; bus.init_lvl = ~l;
      end
      if (poke && c == 4) bus.start = 1'b0;
      dv[c] = bus.d_out;
      sv[c] = bus.pair_strobe;
      if (bus.pair_strobe) strobes++;
      if (bus.done) done_at = c;
    end
    if (done_at == 0) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: no done within %0d cycles (pairs=%0d)", limit, p);
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  int d_at, nst, tog, last_s;
  logic [63:0] dv, sv;
  logic [10:0] bb_busy, bb_done;

  initial begin
    bus.start = 1'b0; bus.pairs = 8'd0; bus.hold = 4'd0; bus.init_lvl = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #11;
    check("reset_d_out", 64'(bus.d_out), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    @(negedge clk) reset_n = 1'b1;

    // Basic: P=2 H=1 L=0
    run(8'd2, 4'd1, 1'b0, 1'b0, 40, d_at, nst, dv, sv);
    check("basic_d_out", dv[6:1], 64'(6'b001010));
    check("basic_strobe", sv[6:1], 64'(6'b010100));
    check("basic_done_at", 64'(d_at), 64'd6);

    // Hold stretch: P=1 H=3 L=1
    run(8'd1, 4'd3, 1'b1, 1'b0, 40, d_at, nst, dv, sv);
    check("h3_d_out", dv[10:1], 64'(10'b1111000111));
    check("h3_strobe", sv[10:1], 64'(10'b0001000000));
    check("h3_done_at", 64'(d_at), 64'd10);

    // hold=0 behaves as H=1
    run(8'd1, 4'd0, 1'b1, 1'b0, 40, d_at, nst, dv, sv);
    check("h0_d_out", dv[4:1], 64'(4'b1101));
    check("h0_done_at", 64'(d_at), 64'd4);

    // Zero pairs: immediate done, line keeps its resting level
    run(8'd0, 4'd2, 1'b0, 1'b0, 10, d_at, nst, dv, sv);
    check("p0_done_at", 64'(d_at), 64'd1);
    check("p0_d_out", 64'(dv[1]), 64'd1);
    check("p0_strobes", 64'(nst), 64'd0);

    // Start pulsed mid-run with new values is ignored
    run(8'd4, 4'd2, 1'b0, 1'b1, 60, d_at, nst, dv, sv);
    check("ign_strobes", 64'(nst), 64'd4);
    check("ign_done_at", 64'(d_at), 64'd19);

    // Back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.pairs = 8'd1; bus.hold = 4'd1; bus.init_lvl = 1'b0;
    nst = 0; bb_busy = 11'd0; bb_done = 11'd0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bb_busy[c] = bus.busy;
      bb_done[c] = bus.done;
      if (bus.pair_strobe) nst++;
      if (c == 10) bus.start = 1'b0;
    end
    check("b2b_busy", 64'(bb_busy[10:1]), 64'(10'b0111101111));
    check("b2b_done", 64'(bb_done[10:1]), 64'(10'b0100001000));
    check("b2b_strobes", 64'(nst), 64'd2);
    @(negedge clk);

    // Asynchronous reset in the middle of TOG1 (P=3 H=2 L=0)
    @(negedge clk);
    bus.start = 1'b1; bus.pairs = 8'd3; bus.hold = 4'd2; bus.init_lvl = 1'b0;
    @(negedge clk) bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_tog1", 64'(bus.d_out), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_d_out", 64'(bus.d_out), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    run(8'd1, 4'd1, 1'b0, 1'b0, 20, d_at, nst, dv, sv);
    check("post_reset_done_at", 64'(d_at), 64'd4);

    // Detector loopback: count completed toggle pairs on d_out (P=5 H=2)
    run(8'd5, 4'd2, 1'b0, 1'b0, 60, d_at, nst, dv, sv);
    tog = 0; last_s = 0;
    for (int c = 2; c <= d_at && c < 64; c++) if (dv[c] != dv[c-1]) tog++;
    for (int c = 1; c <= d_at && c < 64; c++) if (sv[c]) last_s = c;
    check("loop_pairs", 64'(tog / 2), 64'd5);
    check("loop_last_strobe", 64'(last_s), 64'd21);
    check("loop_done_at", 64'(d_at), 64'd23);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/even_toggle_gen.md
# even_toggle_gen

Serial toggle-pair stimulus generator: the transmitting end of the even-toggle detection link. On a start request it drives a single-bit line with a lead-in level followed by a programmed number of toggle pairs, each level held for a programmed number of cycles, so a downstream even-toggle detector sees exactly that many completed pairs. It sits between a control/test sequencer and the detector's serial input.

## Interface
- CNT_W, 8: width of the toggle-pair count.
- HOLD_W, 4: width of the per-level hold length.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge, accepted only when busy=0.
- pairs  input  CNT_W  number of toggle pairs to emit; latched on accept.
- hold  input  HOLD_W  cycles each level is held; latched on accept; 0 is treated as 1.
- init_lvl  input  1  lead-in and resting level; latched on accept.
- d_out  output  1  serial line to detector.
- busy  output  1  high from the cycle after accept through the done cycle.
- pair_strobe  output  1  one-cycle pulse on the cycle d_out makes the second toggle of each pair.
- done  output  1  one-cycle pulse when the sequence completes.

## Operation
- Reset (asynchronous, any time, including mid-sequence): state IDLE, all counters 0, d_out=0, busy=0, pair_strobe=0, done=0. No completion pulse is generated for an aborted sequence.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, LEAD, TOG1, TOG2, FIN.
- IDLE: d_out holds its last value. On start=1: latch P=pairs, H=max(hold,1), L=init_lvl. If P=0, go to FIN without changing d_out. Otherwise go to LEAD.
- LEAD: d_out=L for H cycles, then TOG1.
- TOG1: d_out=~L for H cycles (first toggle), then TOG2.
- TOG2: d_out=L for H cycles (second toggle). pair_strobe=1 on the first cycle of TOG2 only. The remaining-pair counter decrements on TOG2 entry. When the H cycles expire, go to TOG1 if remaining>0, else go to FIN.
- FIN: exactly one cycle; done=1, busy=1, d_out=L (unchanged if P=0). Then go to IDLE.
- The hold counter loads H-1 on each state entry and advances on 0. The pair counter is CNT_W bits, so P is 1..2^CNT_W-1. No wrap: the counter is never decremented below 0.
- start while busy=1, including the FIN cycle, is ignored; it is neither queued nor latched. Changes to pairs, hold or init_lvl while busy have no effect.
- start held high continuously: a new sequence is accepted in the first IDLE cycle after FIN. This gives back-to-back sequences separated by one IDLE cycle.

## Timing
- start accepted at edge T gives, for P>0:
  - LEAD occupies cycles T+1 .. T+H.
  - Pair k (k=1..P) first toggle at T+1+(2k-1)H.
  - Pair k second toggle and pair_strobe at T+1+2kH.
  - FIN/done at T+1+(2P+1)H.
- For P=0: FIN/done at T+1; busy high for that cycle only.
- busy rises at T+1 and falls at the first cycle after FIN.
- d_out transitions per sequence: exactly 2P (plus at most one at LEAD entry if L differs from the prior resting level).

## Test plan
- Reset: assert reset_n=0 mid-TOG1 with P=3, H=2 -> same cycle d_out=0, busy=0, done=0. After release, the block is idle and accepts a new start.
- Basic: P=2, H=1, L=0, start at T -> d_out 0,1,0,1,0 at T+1..T+5. pair_strobe at T+3 and T+5. done at T+6. busy T+1..T+6.
- Hold stretch and hold=0: H=3, P=1, L=1 -> d_out 1 x3, 0 x3, 1 x3, done at T+10. Repeat with hold=0 -> behaves as H=1.
- Zero pairs and ignored start: P=0 -> done at T+1, no d_out change. During a P=4 run, pulse start with new values -> ignored; exactly 4 pair_strobes occur.
- Back-to-back: start tied high, P=1, H=1 -> done, one IDLE cycle, next LEAD. Pair count is unchanged across the boundary.
- Detector loopback: drive the even-toggle detector from d_out with P=5, H=2 -> detector reports 5 pairs; done aligns with the last pair plus H cycles.
